// File: rtl/branch_predictor_btb_if.sv
// Fetch/predict, branch-resolution update and perf-counter bundle for the BTB.
// The master side is the pipeline and the slave side is the predictor.
interface branch_predictor_btb_if #(
    parameter int CTR_W  = 2,
    parameter int PERF_W = 16
);
    logic [31:0]       fetch_pc;
    logic              fetch_valid;
    logic              pred_hit;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [CTR_W-1:0]  pred_state;
    logic              upd_en;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;
    logic              bp_flush;
    logic [PERF_W-1:0] perf_lookups;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output fetch_pc, fetch_valid, upd_en, upd_pc, upd_taken, upd_target,
               upd_mispredict, bp_flush,
        input  pred_hit, pred_taken, pred_target, pred_state,
               perf_lookups, perf_mispredicts
    );

    modport slave (
        input  fetch_pc, fetch_valid, upd_en, upd_pc, upd_taken, upd_target,
               upd_mispredict, bp_flush,
        output pred_hit, pred_taken, pred_target, pred_state,
               perf_lookups, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational off the current array contents; updates and flush
// take effect on the next rising edge, so a same-cycle lookup of an entry
// being written sees the old contents.
module branch_predictor_btb #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8,
    parameter int PERF_W  = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predictor_btb_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_W'(CTR_WT - CTR_W'(1));
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [PERF_W-1:0]  lookups_q;
    logic [PERF_W-1:0]  mispredicts_q;

    logic [IDX_W-1:0]   f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;
    logic [IDX_W-1:0]   u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic               u_hit;
    logic               unused_pc_bits;

    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Low and high PC bits outside idx/tag do not take part in the update.
    assign unused_pc_bits = ^bp.upd_pc;

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Zero-latency prediction from the stored entry at the fetch index.
    always_comb begin
        bp.pred_hit    = f_hit;
        bp.pred_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
        bp.pred_state  = f_hit ? ctr_q[f_idx] : '0;
        bp.pred_target = bp.pred_taken ? target_q[f_idx] : bp.fetch_pc + 32'd4;
    end

    // Entry array: flush beats a same-cycle update; misses allocate only when taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (bp.bp_flush) begin
            valid_q <= '0;
        end else if (bp.upd_en) begin
            if (u_hit) begin
                if (bp.upd_taken) begin
                    if (ctr_q[u_idx] != CTR_MAX) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
                    end
                    target_q[u_idx] <= bp.upd_target;
                end else if (ctr_q[u_idx] != '0) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
                end
            end else if (bp.upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bp.upd_target;
                ctr_q[u_idx]    <= CTR_WT;
            end
        end
    end

    // Saturating perf counters; deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (bp.fetch_valid && lookups_q != PERF_MAX) begin
                lookups_q <= lookups_q + PERF_W'(1);
            end
            if (bp.upd_en && bp.upd_mispredict && mispredicts_q != PERF_MAX) begin
                mispredicts_q <= mispredicts_q + PERF_W'(1);
            end
        end
    end

    assign bp.perf_lookups     = lookups_q;
    assign bp.perf_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES=16, CTR_W=2, TAG_W=8, PERF_W=4).
module tb_branch_predictor_btb;
    localparam int CTR_W  = 2;
    localparam int PERF_W = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    branch_predictor_btb_if #(.CTR_W(CTR_W), .PERF_W(PERF_W)) bp ();

    branch_predictor_btb #(
        .ENTRIES(16),
        .CTR_W  (CTR_W),
        .TAG_W  (8),
        .PERF_W (PERF_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bp.fetch_pc = pc;
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bp.upd_en     = 1'b1;
        bp.upd_pc     = pc;
        bp.upd_taken  = taken;
        bp.upd_target = tgt;
        tick();
        bp.upd_en     = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bp.fetch_pc       = 32'h100;
        bp.fetch_valid    = 1'b0;
        bp.upd_en         = 1'b0;
        bp.upd_pc         = '0;
        bp.upd_taken      = 1'b0;
        bp.upd_target     = '0;
        bp.upd_mispredict = 1'b0;
        bp.bp_flush       = 1'b0;
        #12;
        check_val("rst_hit",    32'(bp.pred_hit),    32'd0);
        check_val("rst_taken",  32'(bp.pred_taken),  32'd0);
        check_val("rst_target", bp.pred_target,      32'h104);
        check_val("rst_state",  32'(bp.pred_state),  32'd0);
        check_val("rst_plook",  32'(bp.perf_lookups),     32'd0);
        check_val("rst_pmis",   32'(bp.perf_mispredicts), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // allocate 0x100 -> weakly taken, target 0x40
        update(32'h100, 1'b1, 32'h40);
        lookup(32'h100);
        check_val("alloc_hit",    32'(bp.pred_hit),   32'd1);
        check_val("alloc_state",  32'(bp.pred_state), 32'd2);
        check_val("alloc_taken",  32'(bp.pred_taken), 32'd1);
        check_val("alloc_target", bp.pred_target,     32'h40);

        // saturate
        update(32'h100, 1'b1, 32'h40);
        update(32'h100, 1'b1, 32'h40);
        lookup(32'h100);
        check_val("sat_state", 32'(bp.pred_state), 32'd3);

        // de-train to 1
        update(32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b0, 32'h0);
        lookup(32'h100);
        check_val("detrain_hit",    32'(bp.pred_hit),   32'd1);
        check_val("detrain_state",  32'(bp.pred_state), 32'd1);
        check_val("detrain_taken",  32'(bp.pred_taken), 32'd0);
        check_val("detrain_target", bp.pred_target,     32'h104);

        // not-taken miss does not allocate
        update(32'h200, 1'b0, 32'h99);
        lookup(32'h200);
        check_val("nt_miss_hit",    32'(bp.pred_hit), 32'd0);
        check_val("nt_miss_target", bp.pred_target,   32'h204);

        // alias eviction: 0x200 shares idx 0 with 0x100
        update(32'h200, 1'b1, 32'h80);
        lookup(32'h200);
        check_val("alias_hit",    32'(bp.pred_hit),   32'd1);
        check_val("alias_target", bp.pred_target,     32'h80);
        check_val("alias_state",  32'(bp.pred_state), 32'd2);
        lookup(32'h100);
        check_val("evicted_hit",    32'(bp.pred_hit), 32'd0);
        check_val("evicted_target", bp.pred_target,   32'h104);

        // no bypass: same-cycle lookup sees old contents
        bp.upd_en     = 1'b1;
        bp.upd_pc     = 32'h100;
        bp.upd_taken  = 1'b1;
        bp.upd_target = 32'h60;
        lookup(32'h100);
        check_val("bypass_same_hit", 32'(bp.pred_hit), 32'd0);
        tick();
        bp.upd_en = 1'b0;
        #1;
        check_val("bypass_next_hit",    32'(bp.pred_hit), 32'd1);
        check_val("bypass_next_target", bp.pred_target,   32'h60);

        // flush wins over a same-cycle update
        bp.bp_flush = 1'b1;
        update(32'h300, 1'b1, 32'h90);
        bp.bp_flush = 1'b0;
        lookup(32'h100);
        check_val("flush_hit_100", 32'(bp.pred_hit), 32'd0);
        lookup(32'h200);
        check_val("flush_hit_200", 32'(bp.pred_hit), 32'd0);
        lookup(32'h300);
        check_val("flush_hit_300", 32'(bp.pred_hit), 32'd0);
        check_val("flush_tgt_300", bp.pred_target,   32'h304);

        // 32-bit wrap of the fall-through target
        lookup(32'hFFFF_FFFC);
        check_val("wrap_target", bp.pred_target, 32'h0);

        // perf counters
        check_val("plook_idle", 32'(bp.perf_lookups), 32'd0);
        bp.fetch_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bp.fetch_valid = 1'b0;
        check_val("plook_sat", 32'(bp.perf_lookups), 32'd15);

        bp.upd_mispredict = 1'b1;
        tick();
        check_val("pmis_no_upd_en", 32'(bp.perf_mispredicts), 32'd0);
        for (int i = 0; i < 3; i++) update(32'h400, 1'b0, 32'h0);
        bp.upd_mispredict = 1'b0;
        check_val("pmis_count", 32'(bp.perf_mispredicts), 32'd3);

        bp.bp_flush = 1'b1;
        tick();
        bp.bp_flush = 1'b0;
        check_val("plook_after_flush", 32'(bp.perf_lookups),     32'd15);
        check_val("pmis_after_flush",  32'(bp.perf_mispredicts), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
